// File: rtl/uc_dispara_tiro_pkg.sv
// Shared definitions for the shot subsystem: FSM state codes and default geometry.
// Used by the fire control unit, the comparison unit and the shot memory.
package uc_dispara_tiro_pkg;

  localparam int N_TIROS_DEF = 4;
  localparam int ADDR_W_DEF  = 2;
  localparam int POS_W_DEF   = 8;

  typedef enum logic [4:0] {
    E_INICIO     = 5'd0,
    E_ESPERA     = 5'd1,
    E_REGISTRA   = 5'd2,
    E_VERIFICA   = 5'd3,
    E_INCREMENTA = 5'd4,
    E_ESCREVE    = 5'd5,
    E_FIM        = 5'd6,
    E_COOLDOWN   = 5'd7,
    E_SEM_SLOT   = 5'd8,
    E_ERRO       = 5'd15
  } estado_t;

endpackage

// File: rtl/uc_dispara_tiro_contador.sv
// Generic mod-M counter: zera clears, conta advances with wrap, rco flags the last value.
module contador_m #(
  parameter int M = 4,
  parameter int W = (M > 1) ? $clog2(M) : 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         zera,
  input  logic         conta,
  output logic [W-1:0] q,
  output logic         rco
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  // Next count: clear has priority over advance.
  always_comb begin
    q_d = q_q;
    if (zera) begin
      q_d = '0;
    end else if (conta) begin
      if (q_q == W'(M - 1)) begin
        q_d = '0;
      end else begin
        q_d = q_q + W'(1);
      end
    end else begin
      q_d = q_q;
    end
  end

  // Count register.
  always_ff @(posedge clock) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q   = q_q;
  assign rco = (q_q == W'(M - 1));

endmodule

// File: rtl/uc_dispara_tiro.sv
// Shot-firing control unit: scans the shot memory for the lowest free slot, writes
// the latched ship position/direction there, then holds off further shots for COOLDOWN cycles.
module uc_dispara_tiro
  import uc_dispara_tiro_pkg::*;
#(
  parameter int N_TIROS  = N_TIROS_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int POS_W    = POS_W_DEF,
  parameter int COOLDOWN = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              dispara,
  input  logic [POS_W-1:0]  posicao_nave,
  input  logic [2:0]        direcao_nave,
  input  logic              tiro_renderizado,
  output logic [ADDR_W-1:0] endereco_tiro,
  output logic              escreve_tiro,
  output logic [POS_W-1:0]  dado_posicao,
  output logic [2:0]        dado_direcao,
  output logic              dado_renderizado,
  output logic              s_fim_disparo,
  output logic              s_sem_slot,
  output logic              ocupado,
  output logic [4:0]        db_estado
);

  localparam int CD_W = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

  estado_t            estado_q, estado_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic [2:0]         dir_q, dir_d;
  logic               slot_zera, slot_conta, slot_rco;
  logic [ADDR_W-1:0]  slot_q;
  logic               cd_zera, cd_conta, cd_rco;
  logic [CD_W-1:0]    unused_cd_q;

  contador_m #(.M(N_TIROS), .W(ADDR_W)) u_slot (
    .clock (clock),
    .reset (reset),
    .zera  (slot_zera),
    .conta (slot_conta),
    .q     (slot_q),
    .rco   (slot_rco)
  );

  contador_m #(.M(COOLDOWN), .W(CD_W)) u_cooldown (
    .clock (clock),
    .reset (reset),
    .zera  (cd_zera),
    .conta (cd_conta),
    .q     (unused_cd_q),
    .rco   (cd_rco)
  );

  // Next-state logic and counter/latch controls.
  always_comb begin
    estado_d   = estado_q;
    pos_d      = pos_q;
    dir_d      = dir_q;
    slot_zera  = 1'b0;
    slot_conta = 1'b0;
    cd_zera    = 1'b0;
    cd_conta   = 1'b0;
    case (estado_q)
      E_INICIO: estado_d = E_ESPERA;
      E_ESPERA: begin
        if (dispara) begin
          estado_d = E_REGISTRA;
        end else begin
          estado_d = E_ESPERA;
        end
      end
      E_REGISTRA: begin
        pos_d     = posicao_nave;
        dir_d     = direcao_nave;
        slot_zera = 1'b1;
        estado_d  = E_VERIFICA;
      end
      E_VERIFICA: begin
        // A slot already passed is never revisited, even if it is cleared meanwhile.
        if (!tiro_renderizado) begin
          estado_d = E_ESCREVE;
        end else if (slot_rco) begin
          estado_d = E_SEM_SLOT;
        end else begin
          estado_d = E_INCREMENTA;
        end
      end
      E_INCREMENTA: begin
        slot_conta = 1'b1;
        estado_d   = E_VERIFICA;
      end
      E_ESCREVE: estado_d = E_FIM;
      E_FIM: begin
        cd_zera  = 1'b1;
        estado_d = E_COOLDOWN;
      end
      E_COOLDOWN: begin
        cd_conta = 1'b1;
        if (cd_rco) begin
          estado_d = E_ESPERA;
        end else begin
          estado_d = E_COOLDOWN;
        end
      end
      E_SEM_SLOT: estado_d = E_ESPERA;
      default:    estado_d = E_INICIO;
    endcase
  end

  // State and latched shot data.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= E_INICIO;
      pos_q    <= '0;
      dir_q    <= 3'd0;
    end else begin
      estado_q <= estado_d;
      pos_q    <= pos_d;
      dir_q    <= dir_d;
    end
  end

  // Moore outputs; ocupado stays low in the reset state so every output is 0 out of reset.
  assign endereco_tiro    = slot_q;
  assign escreve_tiro     = (estado_q == E_ESCREVE);
  assign dado_renderizado = (estado_q == E_ESCREVE);
  assign dado_posicao     = pos_q;
  assign dado_direcao     = dir_q;
  assign s_fim_disparo    = (estado_q == E_FIM);
  assign s_sem_slot       = (estado_q == E_SEM_SLOT);
  assign ocupado          = (estado_q != E_ESPERA) && (estado_q != E_INICIO);
  assign db_estado        = estado_q;

endmodule

// File: tb/tb_uc_dispara_tiro.sv
// Scoreboard bench for uc_dispara_tiro: a transaction-level model predicts each shot
// (slot, data, timing) and a monitor checks the DUT's write/done/no-slot pulses against it.
module tb_uc_dispara_tiro;

  localparam int N  = 4;
  localparam int AW = 2;
  localparam int PW = 8;
  localparam int CD = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          dispara;
  logic [PW-1:0] posicao_nave;
  logic [2:0]    direcao_nave;
  logic          tiro_renderizado;
  logic [AW-1:0] endereco_tiro;
  logic          escreve_tiro;
  logic [PW-1:0] dado_posicao;
  logic [2:0]    dado_direcao;
  logic          dado_renderizado;
  logic          s_fim_disparo;
  logic          s_sem_slot;
  logic          ocupado;
  logic [4:0]    db_estado;

  logic [N-1:0]  mem = '0;
  logic [N-1:0]  set_mask;
  logic [N-1:0]  clr_mask;
  logic [N-1:0]  wr_vec;

  typedef struct {
    int kind;    // 0 write, 1 done, 2 no slot
    int edge_n;
    int addr;
    int pos;
    int dir;
  } ev_t;
  ev_t evq[$];

  int cyc;
  int checks;
  int errors;
  int idle_at;
  int latch_at;
  int last_rst;
  bit pending;
  bit started;

  always #5 clock = ~clock;

  uc_dispara_tiro #(.N_TIROS(N), .ADDR_W(AW), .POS_W(PW), .COOLDOWN(CD)) dut (
    .clock            (clock),
    .reset            (reset),
    .dispara          (dispara),
    .posicao_nave     (posicao_nave),
    .direcao_nave     (direcao_nave),
    .tiro_renderizado (tiro_renderizado),
    .endereco_tiro    (endereco_tiro),
    .escreve_tiro     (escreve_tiro),
    .dado_posicao     (dado_posicao),
    .dado_direcao     (dado_direcao),
    .dado_renderizado (dado_renderizado),
    .s_fim_disparo    (s_fim_disparo),
    .s_sem_slot       (s_sem_slot),
    .ocupado          (ocupado),
    .db_estado        (db_estado)
  );

  // Shot memory stand-in: rendered flags, combinational read, write on the clock edge.
  assign tiro_renderizado = mem[endereco_tiro];
  assign wr_vec = escreve_tiro ? ({{(N-1){1'b0}}, 1'b1} << endereco_tiro) : '0;
  always @(posedge clock) mem <= ((mem | set_mask) & ~clr_mask) | wr_vec;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", nm, act, exp, cyc - 1);
    end
  endtask

  // Reference model: request accepted in idle; at the latch edge pick the lowest free slot.
  initial begin
    int k;
    cyc = 0; idle_at = 0; latch_at = 0; last_rst = -10; pending = 1'b0; started = 1'b0;
    forever begin
      @(posedge clock);
      if (reset === 1'b1) begin
        evq.delete();
        pending  = 1'b0;
        idle_at  = cyc + 2;
        last_rst = cyc;
        started  = 1'b1;
      end else if (pending && cyc == latch_at) begin
        k = -1;
        for (int i = N - 1; i >= 0; i--) if (!mem[i]) k = i;
        if (k >= 0) begin
          evq.push_back('{kind: 0, edge_n: latch_at + 1 + 2 * k, addr: k,
                          pos: int'(posicao_nave), dir: int'(direcao_nave)});
          evq.push_back('{kind: 1, edge_n: latch_at + 2 + 2 * k, addr: 0, pos: 0, dir: 0});
          idle_at = latch_at + 4 + 2 * k + CD;
        end else begin
          evq.push_back('{kind: 2, edge_n: latch_at + 2 * N - 1, addr: 0, pos: 0, dir: 0});
          idle_at = latch_at + 2 * N + 1;
        end
        pending = 1'b0;
      end else if (started && !pending && cyc >= idle_at && dispara === 1'b1) begin
        pending  = 1'b1;
        latch_at = cyc + 1;
        idle_at  = cyc + 1000000;
      end
      cyc++;
    end
  end

  // Monitor: compare pulses and status against the model on the falling edge.
  initial begin
    int t;
    int exp_code;
    int obs_code;
    ev_t e;
    forever begin
      @(negedge clock);
      if (started) begin
        t = cyc - 1;
        exp_code = 0;
        if (evq.size() > 0 && evq[0].edge_n == t)
          exp_code = (evq[0].kind == 0) ? 4 : (evq[0].kind == 1) ? 2 : 1;
        obs_code = {29'd0, escreve_tiro, s_fim_disparo, s_sem_slot};
        chk("event", obs_code, exp_code);
        chk("ocupado", int'(ocupado), int'((t < idle_at - 1) && (t != last_rst)));
        if (t >= idle_at - 1 && t != last_rst) chk("estado_espera", int'(db_estado), 1);
        if (exp_code != 0) begin
          e = evq.pop_front();
          if (e.kind == 0) begin
            chk("endereco", int'(endereco_tiro), e.addr);
            chk("dado_posicao", int'(dado_posicao), e.pos);
            chk("dado_direcao", int'(dado_direcao), e.dir);
            chk("dado_renderizado", int'(dado_renderizado), 1);
            chk("estado_escreve", int'(db_estado), 5);
          end else if (e.kind == 1) begin
            chk("estado_fim", int'(db_estado), 6);
          end else begin
            chk("estado_sem_slot", int'(db_estado), 8);
          end
        end else begin
          chk("dado_rend_quiet", int'(dado_renderizado), 0);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300 && cyc < idle_at; i++) tick();
    if (cyc < idle_at) chk("idle_timeout", cyc, idle_at);
  endtask

  task automatic load_mem(input logic [N-1:0] v);
    wait_idle();
    set_mask = v;
    clr_mask = ~v;
    tick();
    set_mask = '0;
    clr_mask = '0;
  endtask

  task automatic fire(input logic [PW-1:0] p, input logic [2:0] d);
    wait_idle();
    posicao_nave = p;
    direcao_nave = d;
    dispara = 1'b1;
    tick();
    dispara = 1'b0;
    tick();
    posicao_nave = ~p;
    direcao_nave = ~d;
  endtask

  task automatic chk_reset_outs(input string nm);
    chk(nm, int'({endereco_tiro, escreve_tiro, dado_posicao, dado_direcao, dado_renderizado,
                  s_fim_disparo, s_sem_slot, ocupado, db_estado}), 0);
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1; dispara = 1'b0; posicao_nave = '0; direcao_nave = 3'd0;
    set_mask = '0; clr_mask = '1;
    repeat (3) tick();
    chk_reset_outs("reset_outs");
    clr_mask = '0;
    reset = 1'b0;

    fire(8'h35, 3'd3);                 // empty memory: slot 0
    load_mem(4'b0111);
    fire(8'hA2, 3'd6);                 // only slot 3 free
    load_mem(4'b1111);
    fire(8'h5C, 3'd1);                 // all busy: no write, no cooldown
    wait_idle();
    chk("mem_after_sem", int'(mem), 4'hF);

    load_mem(4'b0000);
    wait_idle();
    dispara = 1'b1;                    // held high: auto-fire once per cooldown period
    for (int i = 0; i < 90; i++) begin
      posicao_nave = PW'($urandom);
      direcao_nave = 3'($urandom);
      tick();
    end
    dispara = 1'b0;

    load_mem(4'b0001);                 // reset while the scan is in incrementa
    dispara = 1'b1;
    tick();
    dispara = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk_reset_outs("reset_mid_scan");
    chk("mem_no_partial_write", int'(mem), 1);
    reset = 1'b0;
    fire(8'h77, 3'd7);                 // fires normally into slot 1

    for (int i = 0; i < 2500; i++) begin
      posicao_nave = PW'($urandom);
      direcao_nave = 3'($urandom);
      dispara = ($urandom_range(0, 2) == 0);
      reset = ($urandom_range(0, 299) == 0);
      if (cyc >= idle_at && $urandom_range(0, 3) == 0) begin
        set_mask = N'($urandom);
        clr_mask = N'($urandom);
      end else begin
        set_mask = '0;
        clr_mask = '0;
      end
      tick();
    end
    reset = 1'b0; dispara = 1'b0; set_mask = '0; clr_mask = '0;
    wait_idle();
    repeat (3) tick();
    chk("queue_empty", evq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
